// File: rtl/card_pkg.sv
// Shared card and segment types used by the display scanner and the rank decoder.
//   rank_t : 4-bit card rank code (0 = none, 1..13 = Ace..King)
//   seg_t  : 7-bit segment vector, bit 0 = a ... bit 6 = g
package card_pkg;

  typedef logic [3:0] rank_t;
  typedef logic [6:0] seg_t;

  localparam rank_t RANK_NONE  = 4'd0;
  localparam rank_t RANK_ACE   = 4'd1;
  localparam rank_t RANK_TWO   = 4'd2;
  localparam rank_t RANK_THREE = 4'd3;
  localparam rank_t RANK_FOUR  = 4'd4;
  localparam rank_t RANK_FIVE  = 4'd5;
  localparam rank_t RANK_SIX   = 4'd6;
  localparam rank_t RANK_SEVEN = 4'd7;
  localparam rank_t RANK_EIGHT = 4'd8;
  localparam rank_t RANK_NINE  = 4'd9;
  localparam rank_t RANK_TEN   = 4'd10;
  localparam rank_t RANK_JACK  = 4'd11;
  localparam rank_t RANK_QUEEN = 4'd12;
  localparam rank_t RANK_KING  = 4'd13;

  // Active-low cathode pattern with every segment dark.
  localparam seg_t SEG_OFF = 7'h7F;

endpackage

// File: rtl/bto7s_rank.sv
// Card rank to seven-segment decoder (active-high segments).
//   rank_in : card rank code, 1..13 = Ace..King
//   seg_out : lit segments, bit 0 = a ... bit 6 = g; all zero for codes outside 1..13
module bto7s_rank
  import card_pkg::*;
(
  input  rank_t rank_in,
  output seg_t  seg_out
);

  always_comb begin
    seg_out = '0;
    case (rank_in)
      RANK_ACE:   seg_out = 7'b1110111;  // A
      RANK_TWO:   seg_out = 7'b1011011;
      RANK_THREE: seg_out = 7'b1001111;
      RANK_FOUR:  seg_out = 7'b1100110;
      RANK_FIVE:  seg_out = 7'b1101101;
      RANK_SIX:   seg_out = 7'b1111101;
      RANK_SEVEN: seg_out = 7'b0000111;
      RANK_EIGHT: seg_out = 7'b1111111;
      RANK_NINE:  seg_out = 7'b1101111;
      RANK_TEN:   seg_out = 7'b0111111;  // shown as 0
      RANK_JACK:  seg_out = 7'b0011110;  // J
      RANK_QUEEN: seg_out = 7'b1100111;  // q
      RANK_KING:  seg_out = 7'b1110110;  // H-like K
      default:    seg_out = '0;
    endcase
  end

endmodule

// File: rtl/card_display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner for a hand of cards.
// Holds a displayed snapshot of the hand, accepts new hands through a
// load/ready handshake and swaps the snapshot only at frame wraps so that no
// frame mixes two hands. One selected card can be blinked.
//   clk_in, rst_in   : clock, asynchronous active-high reset
//   hand_in          : packed ranks, digit i = hand_in[4i+3:4i]
//   valid_in         : per-digit "card present" flags
//   load_in          : load request; accepted when load_ready_out is high
//   load_ready_out   : no hand is waiting for a frame wrap
//   sel_in           : digit to blink, blink_en_in enables it
//   cat_out          : active-low cathodes, bit 0 = a ... bit 6 = g
//   an_out           : active-low anodes, one-hot-low while scanning
//   frame_out        : one-cycle pulse in the cycle after each frame wrap
module card_display_scanner
  import card_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_PERIOD = 100000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [4*NUM_DIGITS-1:0]       hand_in,
  input  logic [NUM_DIGITS-1:0]         valid_in,
  input  logic                          load_in,
  output logic                          load_ready_out,
  input  logic [$clog2(NUM_DIGITS)-1:0] sel_in,
  input  logic                          blink_en_in,
  output logic [6:0]                    cat_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic                          frame_out
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(COUNT_PERIOD);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0]             r_cnt;
  logic [IDX_W-1:0]             r_idx;
  logic [FRM_W-1:0]             r_frm;
  logic                         r_blink_on;
  rank_t [NUM_DIGITS-1:0]       r_snap_rank;
  logic  [NUM_DIGITS-1:0]       r_snap_vld;
  rank_t [NUM_DIGITS-1:0]       r_pend_rank;
  logic  [NUM_DIGITS-1:0]       r_pend_vld;
  logic                         r_pend;
  logic [NUM_DIGITS-1:0]        r_an;
  seg_t                         r_cat;
  logic                         r_frame;

  logic                         w_tc;
  logic                         w_wrap;
  logic                         w_frm_tc;
  logic                         w_xfer;
  rank_t                        w_rank;
  seg_t                         w_seg;
  logic                         w_rank_ok;
  logic                         w_blink_off;
  logic                         w_blank;
  logic [NUM_DIGITS-1:0]        w_an;

  assign w_tc     = (r_cnt == CNT_W'(COUNT_PERIOD - 1));
  assign w_wrap   = w_tc && (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_frm_tc = (r_frm == FRM_W'(BLINK_FRAMES - 1));
  // A pending hand blocks further loads until it has been applied.
  assign w_xfer   = load_in && !r_pend;

  // Scan counter and digit index
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Blink timing keeps running whether or not blinking is enabled, so enabling
  // it mid-stream joins the existing phase.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_frm      <= '0;
      r_blink_on <= 1'b1;
    end else if (w_wrap) begin
      if (w_frm_tc) begin
        r_frm      <= '0;
        r_blink_on <= !r_blink_on;
      end else begin
        r_frm <= r_frm + FRM_W'(1);
      end
    end
  end

  // Load handshake. Applying the pending hand and accepting a new one are
  // exclusive because acceptance requires the pending flag to be clear, so a
  // load that lands on a wrap cycle waits for the following wrap.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pend      <= 1'b0;
      r_pend_rank <= '0;
      r_pend_vld  <= '0;
      r_snap_rank <= '0;
      r_snap_vld  <= '0;
    end else if (w_wrap && r_pend) begin
      r_snap_rank <= r_pend_rank;
      r_snap_vld  <= r_pend_vld;
      r_pend      <= 1'b0;
    end else if (w_xfer) begin
      r_pend_rank <= hand_in;
      r_pend_vld  <= valid_in;
      r_pend      <= 1'b1;
    end
  end

  assign load_ready_out = !r_pend;

  assign w_rank = r_snap_rank[r_idx];

  bto7s_rank u_dec (
    .rank_in (w_rank),
    .seg_out (w_seg)
  );

  assign w_rank_ok   = (w_rank >= RANK_ACE) && (w_rank <= RANK_KING);
  // r_idx never reaches NUM_DIGITS, so an out-of-range sel_in never matches.
  assign w_blink_off = blink_en_in && (sel_in == r_idx) && !r_blink_on;
  assign w_blank     = !r_snap_vld[r_idx] || !w_rank_ok || w_blink_off;
  assign w_an        = ~(NUM_DIGITS'(1) << r_idx);

  // Output register stage: pins follow the digit index one cycle later
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_an    <= '1;
      r_cat   <= SEG_OFF;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_an;
      r_cat   <= w_blank ? SEG_OFF : ~w_seg;
      r_frame <= w_wrap;
    end
  end

  assign an_out    = r_an;
  assign cat_out   = r_cat;
  assign frame_out = r_frame;

endmodule

// File: tb/tb_card_display_scanner.sv
module tb_card_display_scanner;

  localparam int N     = 4;
  localparam int CP    = 4;
  localparam int BF    = 2;
  localparam int FRAME = N * CP;

  logic           clk = 1'b0;
  logic           rst;
  logic [4*N-1:0] hand;
  logic [N-1:0]   valid;
  logic           load;
  logic           ready;
  logic [1:0]     sel;
  logic           blink_en;
  logic [6:0]     cat;
  logic [N-1:0]   an;
  logic           frame;

  always #5 clk = ~clk;

  card_display_scanner #(
    .NUM_DIGITS   (N),
    .COUNT_PERIOD (CP),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .hand_in        (hand),
    .valid_in       (valid),
    .load_in        (load),
    .load_ready_out (ready),
    .sel_in         (sel),
    .blink_en_in    (blink_en),
    .cat_out        (cat),
    .an_out         (an),
    .frame_out      (frame)
  );

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   cat;
    logic         frame;
    logic         ready;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: edges since reset release, snapshot and pending hand.
  int             edge_k;
  logic [4*N-1:0] m_snap_hand, m_pend_hand;
  logic [N-1:0]   m_snap_vld, m_pend_vld;
  logic           m_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Active-high segment pattern of each rank (gfedcba).
  function automatic logic [6:0] seg_of(input int r);
    case (r)
      1:       return 7'b1110111;
      2:       return 7'b1011011;
      3:       return 7'b1001111;
      4:       return 7'b1100110;
      5:       return 7'b1101101;
      6:       return 7'b1111101;
      7:       return 7'b0000111;
      8:       return 7'b1111111;
      9:       return 7'b1101111;
      10:      return 7'b0111111;
      11:      return 7'b0011110;
      12:      return 7'b1100111;
      13:      return 7'b1110110;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic model_reset();
    edge_k      = 0;
    m_snap_hand = '0;
    m_snap_vld  = '0;
    m_pend_hand = '0;
    m_pend_vld  = '0;
    m_pend      = 1'b0;
  endtask

  // One clock edge: predict the registered outputs after this edge from the
  // time since reset and the model's hand state, then advance the model.
  task automatic step();
    exp_t e;
    int   idx, wraps, r;
    logic on;
    @(posedge clk);
    edge_k++;
    idx   = ((edge_k - 1) / CP) % N;
    wraps = (edge_k - 1) / FRAME;
    on    = ((wraps / BF) % 2) == 0;
    r     = int'(m_snap_hand[4*idx +: 4]);
    e.an  = ~(4'b0001 << idx);
    if (m_snap_vld[idx] && r >= 1 && r <= 13 && !(blink_en && int'(sel) == idx && !on))
      e.cat = ~seg_of(r);
    else
      e.cat = 7'h7F;
    e.frame = (edge_k % FRAME) == 0;
    if ((edge_k % FRAME) == 0 && m_pend) begin
      m_snap_hand = m_pend_hand;
      m_snap_vld  = m_pend_vld;
      m_pend      = 1'b0;
    end else if (load && !m_pend) begin
      m_pend_hand = hand;
      m_pend_vld  = valid;
      m_pend      = 1'b1;
    end
    e.ready = !m_pend;
    sb_q.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check_eq("an",    32'(an),    32'(mon_e.an));
      check_eq("cat",   32'(cat),   32'(mon_e.cat));
      check_eq("frame", 32'(frame), 32'(mon_e.frame));
      check_eq("ready", 32'(ready), 32'(mon_e.ready));
    end
  end

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    hand     = '0;
    valid    = '0;
    sel      = '0;
    blink_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_an",    32'(an),    32'hF);
    check_eq("rst_cat",   32'(cat),   32'h7F);
    check_eq("rst_ready", 32'(ready), 32'h1);
    check_eq("rst_frame", 32'(frame), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("first_an",  32'(an),  32'hF);
    check_eq("first_cat", 32'(cat), 32'h7F);

    // Idle scan, no hand loaded.
    run(40);

    // Mid-frame load of {K, none, 10, A}.
    hand = {4'd13, 4'd0, 4'd10, 4'd1}; valid = 4'b1111; load = 1'b1;
    step();
    load = 1'b0;
    run(2);
    check_eq("ready_low", 32'(ready), 32'h0);

    // Second load while busy must be ignored.
    hand = {4'd2, 4'd3, 4'd4, 4'd5}; valid = 4'b1111; load = 1'b1;
    step();
    load = 1'b0;
    run(40);

    // Load landing exactly on the frame-wrap edge.
    while ((edge_k % FRAME) != FRAME - 1) step();
    hand = {4'd12, 4'd7, 4'd11, 4'd5}; valid = 4'b1111; load = 1'b1;
    step();
    load = 1'b0;
    run(40);

    // Blink digit 2 over two full blink periods.
    blink_en = 1'b1; sel = 2'd2;
    run(140);
    blink_en = 1'b0;

    // Out-of-range ranks and a blank digit.
    hand = {4'd15, 4'd9, 4'd14, 4'd3}; valid = 4'b0111; load = 1'b1;
    step();
    load = 1'b0;
    run(40);

    // Asynchronous reset mid-digit with a hand pending.
    hand = {4'd1, 4'd1, 4'd1, 4'd1}; valid = 4'b1111; load = 1'b1;
    step();
    load = 1'b0;
    run(3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_an",    32'(an),    32'hF);
    check_eq("arst_cat",   32'(cat),   32'h7F);
    check_eq("arst_ready", 32'(ready), 32'h1);
    check_eq("arst_frame", 32'(frame), 32'h0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("rel_ready", 32'(ready), 32'h1);
    run(40);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
